// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared pipeline definitions for the ID/EX stage: ALU operation
//               codes, forwarding-source encoding and the forwarding-match
//               helper used by both operand forwarding units.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // ALU operation codes carried down the pipe to the execute unit
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    // Operand source chosen by a forwarding unit
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // A later stage may supply an operand only when it is writing the very
    // register being read. r0 is hard-wired, so it is never a forward target.
    function automatic logic fwd_hit(
        input logic                  src_we,
        input logic [REG_ADDR_W-1:0] src_rd,
        input logic [REG_ADDR_W-1:0] rd_addr
    );
        return src_we && (src_rd == rd_addr) && (rd_addr != REG_ZERO);
    endfunction

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel
// Description : Operand forwarding multiplexer for one source register.
//               Picks EX/MEM result, MEM/WB result or the stored register-file
//               value, with EX/MEM taking precedence as the younger result.
// Ports       : i_addr            - registered source register number
//               i_reg_data        - registered register-file operand
//               i_exmem_reg_write - EX/MEM stage will write a register
//               i_exmem_rd        - EX/MEM destination register
//               i_exmem_result    - EX/MEM result value
//               i_memwb_reg_write - MEM/WB stage will write a register
//               i_memwb_rd        - MEM/WB destination register
//               i_memwb_result    - MEM/WB result value
//               o_data            - forwarded operand
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       i_addr,
    input  logic [WIDTH-1:0] i_reg_data,
    input  logic             i_exmem_reg_write,
    input  logic [4:0]       i_exmem_rd,
    input  logic [WIDTH-1:0] i_exmem_result,
    input  logic             i_memwb_reg_write,
    input  logic [4:0]       i_memwb_rd,
    input  logic [WIDTH-1:0] i_memwb_result,
    output logic [WIDTH-1:0] o_data
);

    fwd_sel_e w_sel;

    // Source selection; the EX/MEM check comes first so it wins a double match
    always_comb begin
        w_sel = FWD_REG;
        if (fwd_hit(i_exmem_reg_write, i_exmem_rd, i_addr)) begin
            w_sel = FWD_EXMEM;
        end else if (fwd_hit(i_memwb_reg_write, i_memwb_rd, i_addr)) begin
            w_sel = FWD_MEMWB;
        end
    end

    always_comb begin
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_result;
            default:   o_data = i_reg_data;
        endcase
    end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with operand forwarding and load-use
//               hazard detection. Captures decoded operands and control bits,
//               supports stall (hold) and flush (bubble), and presents the
//               forwarded ALU operands and store data to the execute stage.
// Ports       : i_clk, i_rst_n      - clock, synchronous active-low reset
//               i_stall, i_flush    - hold contents / load a bubble
//               i_valid + decode    - instruction fields from decode
//               i_exmem_*, i_memwb_* - forwarding sources
//               o_valid, o_src1, o_src2, o_store_data - execute operands
//               o_alu_ctrl, o_shamt, o_rd_addr, o_reg_write, o_mem_read,
//               o_mem_write, o_mem_to_reg - registered control to execute
//               o_load_use_hazard   - stall request back to decode
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic [WIDTH-1:0] i_rt_data,
    input  logic [WIDTH-1:0] i_imm,
    input  logic [4:0]       i_rs_addr,
    input  logic [4:0]       i_rt_addr,
    input  logic [4:0]       i_rd_addr,
    input  logic [3:0]       i_alu_ctrl,
    input  logic [4:0]       i_shamt,
    input  logic             i_alu_src,
    input  logic             i_reg_write,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic             i_mem_to_reg,
    input  logic             i_exmem_reg_write,
    input  logic [4:0]       i_exmem_rd,
    input  logic [WIDTH-1:0] i_exmem_result,
    input  logic             i_memwb_reg_write,
    input  logic [4:0]       i_memwb_rd,
    input  logic [WIDTH-1:0] i_memwb_result,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_src1,
    output logic [WIDTH-1:0] o_src2,
    output logic [WIDTH-1:0] o_store_data,
    output logic [3:0]       o_alu_ctrl,
    output logic [4:0]       o_shamt,
    output logic [4:0]       o_rd_addr,
    output logic             o_reg_write,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_mem_to_reg,
    output logic             o_load_use_hazard
);

    // ------------------------------------------------------------------
    // Pipeline register state
    // ------------------------------------------------------------------
    logic             r_valid_q,      w_valid_d;
    logic [WIDTH-1:0] r_rs_data_q,    w_rs_data_d;
    logic [WIDTH-1:0] r_rt_data_q,    w_rt_data_d;
    logic [WIDTH-1:0] r_imm_q,        w_imm_d;
    logic [4:0]       r_rs_addr_q,    w_rs_addr_d;
    logic [4:0]       r_rt_addr_q,    w_rt_addr_d;
    logic [4:0]       r_rd_addr_q,    w_rd_addr_d;
    logic [3:0]       r_alu_ctrl_q,   w_alu_ctrl_d;
    logic [4:0]       r_shamt_q,      w_shamt_d;
    logic             r_alu_src_q,    w_alu_src_d;
    logic             r_reg_write_q,  w_reg_write_d;
    logic             r_mem_read_q,   w_mem_read_d;
    logic             r_mem_write_q,  w_mem_write_d;
    logic             r_mem_to_reg_q, w_mem_to_reg_d;

    logic [WIDTH-1:0] w_rs_fwd;
    logic [WIDTH-1:0] w_rt_fwd;

    // ------------------------------------------------------------------
    // Next-state: flush beats stall; an idle decode slot becomes a bubble.
    // Reset is applied in the register process and beats everything.
    // ------------------------------------------------------------------
    always_comb begin
        // default: hold (stall)
        w_valid_d      = r_valid_q;
        w_rs_data_d    = r_rs_data_q;
        w_rt_data_d    = r_rt_data_q;
        w_imm_d        = r_imm_q;
        w_rs_addr_d    = r_rs_addr_q;
        w_rt_addr_d    = r_rt_addr_q;
        w_rd_addr_d    = r_rd_addr_q;
        w_alu_ctrl_d   = r_alu_ctrl_q;
        w_shamt_d      = r_shamt_q;
        w_alu_src_d    = r_alu_src_q;
        w_reg_write_d  = r_reg_write_q;
        w_mem_read_d   = r_mem_read_q;
        w_mem_write_d  = r_mem_write_q;
        w_mem_to_reg_d = r_mem_to_reg_q;

        if (i_flush || (!i_stall && !i_valid)) begin
            w_valid_d      = 1'b0;
            w_rs_data_d    = '0;
            w_rt_data_d    = '0;
            w_imm_d        = '0;
            w_rs_addr_d    = REG_ZERO;
            w_rt_addr_d    = REG_ZERO;
            w_rd_addr_d    = REG_ZERO;
            w_alu_ctrl_d   = ALU_ADD;
            w_shamt_d      = 5'd0;
            w_alu_src_d    = 1'b0;
            w_reg_write_d  = 1'b0;
            w_mem_read_d   = 1'b0;
            w_mem_write_d  = 1'b0;
            w_mem_to_reg_d = 1'b0;
        end else if (!i_stall) begin
            w_valid_d      = 1'b1;
            w_rs_data_d    = i_rs_data;
            w_rt_data_d    = i_rt_data;
            w_imm_d        = i_imm;
            w_rs_addr_d    = i_rs_addr;
            w_rt_addr_d    = i_rt_addr;
            w_rd_addr_d    = i_rd_addr;
            w_alu_ctrl_d   = i_alu_ctrl;
            w_shamt_d      = i_shamt;
            w_alu_src_d    = i_alu_src;
            w_reg_write_d  = i_reg_write;
            w_mem_read_d   = i_mem_read;
            w_mem_write_d  = i_mem_write;
            w_mem_to_reg_d = i_mem_to_reg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid_q      <= 1'b0;
            r_rs_data_q    <= '0;
            r_rt_data_q    <= '0;
            r_imm_q        <= '0;
            r_rs_addr_q    <= REG_ZERO;
            r_rt_addr_q    <= REG_ZERO;
            r_rd_addr_q    <= REG_ZERO;
            r_alu_ctrl_q   <= ALU_ADD;
            r_shamt_q      <= 5'd0;
            r_alu_src_q    <= 1'b0;
            r_reg_write_q  <= 1'b0;
            r_mem_read_q   <= 1'b0;
            r_mem_write_q  <= 1'b0;
            r_mem_to_reg_q <= 1'b0;
        end else begin
            r_valid_q      <= w_valid_d;
            r_rs_data_q    <= w_rs_data_d;
            r_rt_data_q    <= w_rt_data_d;
            r_imm_q        <= w_imm_d;
            r_rs_addr_q    <= w_rs_addr_d;
            r_rt_addr_q    <= w_rt_addr_d;
            r_rd_addr_q    <= w_rd_addr_d;
            r_alu_ctrl_q   <= w_alu_ctrl_d;
            r_shamt_q      <= w_shamt_d;
            r_alu_src_q    <= w_alu_src_d;
            r_reg_write_q  <= w_reg_write_d;
            r_mem_read_q   <= w_mem_read_d;
            r_mem_write_q  <= w_mem_write_d;
            r_mem_to_reg_q <= w_mem_to_reg_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding. Upstream valid is not consulted: the later stages
    // are expected to deassert reg_write for their own bubbles.
    // ------------------------------------------------------------------
    fwd_sel #(
        .WIDTH (WIDTH)
    ) u_fwd_rs (
        .i_addr            (r_rs_addr_q),
        .i_reg_data        (r_rs_data_q),
        .i_exmem_reg_write (i_exmem_reg_write),
        .i_exmem_rd        (i_exmem_rd),
        .i_exmem_result    (i_exmem_result),
        .i_memwb_reg_write (i_memwb_reg_write),
        .i_memwb_rd        (i_memwb_rd),
        .i_memwb_result    (i_memwb_result),
        .o_data            (w_rs_fwd)
    );

    fwd_sel #(
        .WIDTH (WIDTH)
    ) u_fwd_rt (
        .i_addr            (r_rt_addr_q),
        .i_reg_data        (r_rt_data_q),
        .i_exmem_reg_write (i_exmem_reg_write),
        .i_exmem_rd        (i_exmem_rd),
        .i_exmem_result    (i_exmem_result),
        .i_memwb_reg_write (i_memwb_reg_write),
        .i_memwb_rd        (i_memwb_rd),
        .i_memwb_result    (i_memwb_result),
        .o_data            (w_rt_fwd)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_valid      = r_valid_q;
    assign o_src1       = w_rs_fwd;
    // Immediate replaces rt on the ALU input only; stores always need rt
    assign o_src2       = r_alu_src_q ? r_imm_q : w_rt_fwd;
    assign o_store_data = w_rt_fwd;
    assign o_alu_ctrl   = r_alu_ctrl_q;
    assign o_shamt      = r_shamt_q;
    assign o_rd_addr    = r_rd_addr_q;
    assign o_reg_write  = r_reg_write_q;
    assign o_mem_read   = r_mem_read_q;
    assign o_mem_write  = r_mem_write_q;
    assign o_mem_to_reg = r_mem_to_reg_q;

    // A load in EX cannot forward until MEM completes, so a dependent
    // instruction sitting in decode must be held back one cycle.
    assign o_load_use_hazard = r_valid_q && r_mem_read_q
                               && (r_rd_addr_q != REG_ZERO) && i_valid
                               && ((r_rd_addr_q == i_rs_addr) || (r_rd_addr_q == i_rt_addr));

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A behavioural model of
//               the stage contents is compared against every output on each
//               falling edge; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int W = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n, i_stall, i_flush, i_valid;
    logic [W-1:0]  i_rs_data, i_rt_data, i_imm;
    logic [4:0]    i_rs_addr, i_rt_addr, i_rd_addr;
    logic [3:0]    i_alu_ctrl;
    logic [4:0]    i_shamt;
    logic          i_alu_src, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
    logic          i_exmem_reg_write, i_memwb_reg_write;
    logic [4:0]    i_exmem_rd, i_memwb_rd;
    logic [W-1:0]  i_exmem_result, i_memwb_result;
    logic          o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_load_use_hazard;
    logic [W-1:0]  o_src1, o_src2, o_store_data;
    logic [3:0]    o_alu_ctrl;
    logic [4:0]    o_shamt, o_rd_addr;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    id_ex_stage #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr),
        .i_alu_ctrl(i_alu_ctrl), .i_shamt(i_shamt), .i_alu_src(i_alu_src),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_to_reg(i_mem_to_reg), .i_exmem_reg_write(i_exmem_reg_write),
        .i_exmem_rd(i_exmem_rd), .i_exmem_result(i_exmem_result),
        .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_rd(i_memwb_rd),
        .i_memwb_result(i_memwb_result), .o_valid(o_valid), .o_src1(o_src1),
        .o_src2(o_src2), .o_store_data(o_store_data), .o_alu_ctrl(o_alu_ctrl),
        .o_shamt(o_shamt), .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
        .o_load_use_hazard(o_load_use_hazard)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic         valid;
        logic [W-1:0] rs_data, rt_data, imm;
        logic [4:0]   rs_addr, rt_addr, rd_addr, shamt;
        logic [3:0]   alu_ctrl;
        logic         alu_src, reg_write, mem_read, mem_write, mem_to_reg;
    } stage_t;

    stage_t m;
    logic   m_known = 1'b0;

    function automatic stage_t bubble();
        stage_t b;
        b.valid = 0; b.rs_data = 0; b.rt_data = 0; b.imm = 0;
        b.rs_addr = 0; b.rt_addr = 0; b.rd_addr = 0; b.shamt = 0; b.alu_ctrl = 0;
        b.alu_src = 0; b.reg_write = 0; b.mem_read = 0; b.mem_write = 0; b.mem_to_reg = 0;
        return b;
    endfunction

    function automatic stage_t capture();
        stage_t c;
        c.valid = 1; c.rs_data = i_rs_data; c.rt_data = i_rt_data; c.imm = i_imm;
        c.rs_addr = i_rs_addr; c.rt_addr = i_rt_addr; c.rd_addr = i_rd_addr;
        c.shamt = i_shamt; c.alu_ctrl = i_alu_ctrl; c.alu_src = i_alu_src;
        c.reg_write = i_reg_write; c.mem_read = i_mem_read;
        c.mem_write = i_mem_write; c.mem_to_reg = i_mem_to_reg;
        return c;
    endfunction

    // Value a consumer of register 'addr' must see this cycle
    function automatic logic [W-1:0] fwd(input logic [4:0] addr, input logic [W-1:0] stored);
        if (addr == 0) return stored;
        if (i_exmem_reg_write && i_exmem_rd == addr) return i_exmem_result;
        if (i_memwb_reg_write && i_memwb_rd == addr) return i_memwb_result;
        return stored;
    endfunction

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            m <= bubble();
            m_known <= 1'b1;
        end else if (i_flush) m <= bubble();
        else if (i_stall)     m <= m;
        else if (i_valid)     m <= capture();
        else                  m <= bubble();
    end

    always @(negedge i_clk) begin
        if (m_known) begin
            logic [W-1:0] rt_v;
            logic         haz;
            rt_v = fwd(m.rt_addr, m.rt_data);
            haz  = m.valid && m.mem_read && m.rd_addr != 0 && i_valid
                   && (m.rd_addr == i_rs_addr || m.rd_addr == i_rt_addr);
            chk("m_valid",      64'(o_valid),      64'(m.valid));
            chk("m_src1",       64'(o_src1),       64'(fwd(m.rs_addr, m.rs_data)));
            chk("m_src2",       64'(o_src2),       64'(m.alu_src ? m.imm : rt_v));
            chk("m_store_data", 64'(o_store_data), 64'(rt_v));
            chk("m_alu_ctrl",   64'(o_alu_ctrl),   64'(m.alu_ctrl));
            chk("m_shamt",      64'(o_shamt),      64'(m.shamt));
            chk("m_rd_addr",    64'(o_rd_addr),    64'(m.rd_addr));
            chk("m_reg_write",  64'(o_reg_write),  64'(m.reg_write));
            chk("m_mem_read",   64'(o_mem_read),   64'(m.mem_read));
            chk("m_mem_write",  64'(o_mem_write),  64'(m.mem_write));
            chk("m_mem_to_reg", 64'(o_mem_to_reg), 64'(m.mem_to_reg));
            chk("m_hazard",     64'(o_load_use_hazard), 64'(haz));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic present(input logic [4:0] rs_a, input logic [4:0] rt_a, input logic [4:0] rd_a,
                           input logic [W-1:0] rs_d, input logic [W-1:0] rt_d, input logic [W-1:0] imm,
                           input logic [3:0] alu, input logic [4:0] sh, input logic asrc,
                           input logic rw, input logic mr, input logic mw, input logic m2r);
        i_valid = 1; i_rs_addr = rs_a; i_rt_addr = rt_a; i_rd_addr = rd_a;
        i_rs_data = rs_d; i_rt_data = rt_d; i_imm = imm; i_alu_ctrl = alu; i_shamt = sh;
        i_alu_src = asrc; i_reg_write = rw; i_mem_read = mr; i_mem_write = mw; i_mem_to_reg = m2r;
    endtask

    task automatic clear_fwd();
        i_exmem_reg_write = 0; i_exmem_rd = 0; i_exmem_result = 0;
        i_memwb_reg_write = 0; i_memwb_rd = 0; i_memwb_result = 0;
    endtask

    initial begin
        i_rst_n = 0; i_stall = 0; i_flush = 0;
        present(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        i_valid = 0;
        clear_fwd();
        repeat (3) step();
        chk("rst_valid",  64'(o_valid), 64'd0);
        chk("rst_hazard", 64'(o_load_use_hazard), 64'd0);
        chk("rst_src1",   64'(o_src1), 64'd0);
        i_rst_n = 1;

        // add r3 = r1 + r2
        present(1, 2, 3, 32'd5, 32'd7, 0, 4'b0000, 0, 0, 1, 0, 0, 0);
        step(); i_valid = 0;
        chk("add_src1",  64'(o_src1), 64'd5);
        chk("add_src2",  64'(o_src2), 64'd7);
        chk("add_alu",   64'(o_alu_ctrl), 64'd0);
        chk("add_valid", 64'(o_valid), 64'd1);

        // forwarding priority on r4
        present(4, 4, 9, 32'h99, 32'h77, 32'h1234, 4'b0001, 0, 0, 1, 0, 0, 0);
        step(); i_valid = 0;
        i_exmem_reg_write = 1; i_exmem_rd = 4; i_exmem_result = 32'h11;
        i_memwb_reg_write = 1; i_memwb_rd = 4; i_memwb_result = 32'h22;
        #1 chk("fwd_both_src1",  64'(o_src1), 64'h11);
        chk("fwd_both_store", 64'(o_store_data), 64'h11);
        i_exmem_reg_write = 0;
        #1 chk("fwd_memwb_src1", 64'(o_src1), 64'h22);
        i_memwb_reg_write = 0;
        #1 chk("fwd_none_src1",  64'(o_src1), 64'h99);
        chk("fwd_none_src2",  64'(o_src2), 64'h77);

        // immediate operand while store data still forwards rt
        present(4, 4, 9, 32'h99, 32'h77, 32'h1234, 4'b0101, 5'd3, 1, 1, 0, 0, 0);
        i_exmem_reg_write = 1; i_exmem_rd = 4; i_exmem_result = 32'h11;
        step(); i_valid = 0;
        chk("imm_src2",  64'(o_src2), 64'h1234);
        chk("imm_store", 64'(o_store_data), 64'h11);
        chk("imm_shamt", 64'(o_shamt), 64'd3);
        clear_fwd();

        // r0 is never forwarded
        present(0, 0, 5, 32'hAB, 32'hCD, 0, 4'b0010, 0, 0, 1, 0, 0, 0);
        i_exmem_reg_write = 1; i_exmem_rd = 0; i_exmem_result = 32'hFF;
        i_memwb_reg_write = 1; i_memwb_rd = 0; i_memwb_result = 32'hEE;
        step(); i_valid = 0;
        chk("r0_src1",  64'(o_src1), 64'hAB);
        chk("r0_store", 64'(o_store_data), 64'hCD);
        clear_fwd();

        // lw r8 followed by a dependent instruction in decode
        present(10, 11, 8, 32'h100, 32'h200, 32'h4, 4'b0000, 0, 1, 1, 1, 0, 1);
        step();
        i_valid = 1; i_rs_addr = 3; i_rt_addr = 8;
        #1 chk("lu_hazard_rt", 64'(o_load_use_hazard), 64'd1);
        i_rt_addr = 9;
        #1 chk("lu_hazard_none", 64'(o_load_use_hazard), 64'd0);
        i_rt_addr = 8; i_stall = 1;
        step();
        chk("stall_rd",     64'(o_rd_addr), 64'd8);
        chk("stall_mread",  64'(o_mem_read), 64'd1);
        chk("stall_src1",   64'(o_src1), 64'h100);
        chk("stall_src2",   64'(o_src2), 64'h4);
        chk("stall_hazard", 64'(o_load_use_hazard), 64'd1);
        i_stall = 0;

        // stall + flush together loads a bubble
        present(6, 7, 0, 32'h60, 32'h70, 32'h8, 4'b0000, 0, 1, 0, 0, 1, 0);
        step();
        chk("sw_mwrite", 64'(o_mem_write), 64'd1);
        i_stall = 1; i_flush = 1;
        step();
        chk("flush_valid",  64'(o_valid), 64'd0);
        chk("flush_mwrite", 64'(o_mem_write), 64'd0);
        chk("flush_src1",   64'(o_src1), 64'd0);
        i_stall = 0; i_flush = 0;

        // idle decode loads a bubble
        present(1, 2, 3, 32'h5, 32'h6, 0, 4'b0011, 0, 0, 1, 0, 0, 0);
        step(); i_valid = 0;
        step();
        chk("idle_valid", 64'(o_valid), 64'd0);
        chk("idle_rw",    64'(o_reg_write), 64'd0);

        // reset during stall clears everything
        present(12, 13, 14, 32'hDEAD, 32'hBEEF, 32'h55, 4'b1001, 5'd7, 1, 1, 1, 1, 1);
        step();
        i_stall = 1; i_rst_n = 0;
        step();
        chk("rs_valid", 64'(o_valid), 64'd0);
        chk("rs_src1",  64'(o_src1), 64'd0);
        chk("rs_src2",  64'(o_src2), 64'd0);
        chk("rs_alu",   64'(o_alu_ctrl), 64'd0);
        chk("rs_shamt", 64'(o_shamt), 64'd0);
        chk("rs_rd",    64'(o_rd_addr), 64'd0);
        chk("rs_ctrl",  64'({o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg}), 64'd0);
        i_rst_n = 1; i_stall = 0;

        // mixed sequence exercised against the model
        for (int i = 0; i < 24; i++) begin
            present(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom, $urandom, $urandom, 4'($urandom_range(0, 9)), 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            i_valid = (i % 5) != 4;
            i_stall = (i % 4) == 2;
            i_flush = (i % 7) == 6;
            i_exmem_reg_write = 1'($urandom); i_exmem_rd = 5'($urandom_range(0, 3));
            i_exmem_result = $urandom;
            i_memwb_reg_write = 1'($urandom); i_memwb_rd = 5'($urandom_range(0, 3));
            i_memwb_result = $urandom;
            step();
        end
        i_stall = 0; i_flush = 0; i_valid = 0;
        clear_fwd();
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and results.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_stall  in  1  hold all registered contents.
REQ-005 i_flush  in  1  load a bubble.
REQ-006 i_valid  in  1  decode stage presents an instruction.
REQ-007 i_rs_data, i_rt_data, i_imm  in  WIDTH each  register-file operands and sign-extended immediate.
REQ-008 i_rs_addr, i_rt_addr, i_rd_addr  in  5 each  source and destination register numbers.
REQ-009 i_alu_ctrl  in  4 and i_shamt  in  5  ALU operation code and shift amount.
REQ-010 i_alu_src, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1 each  decode control bits; i_alu_src=1 selects the immediate.
REQ-011 i_exmem_reg_write  in  1, i_exmem_rd  in  5, i_exmem_result  in  WIDTH  EX/MEM forwarding source.
REQ-012 i_memwb_reg_write  in  1, i_memwb_rd  in  5, i_memwb_result  in  WIDTH  MEM/WB forwarding source.
REQ-013 o_valid  out  1; o_src1, o_src2, o_store_data  out  WIDTH  ALU operands and forwarded rt.
REQ-014 o_alu_ctrl  out  4; o_shamt  out  5; o_rd_addr  out  5; o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1 each.
REQ-015 o_load_use_hazard  out  1  stall request to decode.

Function
REQ-016 Pipeline register latency SHALL be one cycle: fields captured at edge N appear on outputs during cycle N+1.
REQ-017 Priority per edge SHALL be reset > flush > stall > load.
REQ-018 Flush SHALL load a bubble: valid, reg_write, mem_read, mem_write, mem_to_reg = 0; all data/address fields = 0; alu_ctrl = 4'b0000 (ADD).
REQ-019 Stall without flush SHALL hold every registered field unchanged.
REQ-020 Load with i_valid=0 SHALL load a bubble, identical to REQ-018.
REQ-021 Operand A forward select SHALL be combinational from registered rs_addr: EX/MEM if exmem_reg_write and exmem_rd==rs_addr and rs_addr!=0; else MEM/WB under the same conditions; else registered rs_data.
REQ-022 Operand B forwarding (rt) SHALL use identical rules; EX/MEM wins when both sources match.
REQ-023 Register 0 SHALL never be forwarded; a registered operand read of r0 SHALL pass as stored.
REQ-024 o_src1 SHALL equal forwarded rs; o_src2 SHALL equal registered imm if registered alu_src=1, else forwarded rt.
REQ-025 o_store_data SHALL equal forwarded rt regardless of alu_src.
REQ-026 o_load_use_hazard SHALL be 1 when o_valid, registered mem_read, rd_addr!=0 and rd_addr equals i_rs_addr or i_rt_addr with i_valid=1; else 0.
REQ-027 Forwarding SHALL ignore o_valid of upstream sources; callers gate reg_write.

Reset
REQ-028 On an edge with i_rst_n=0 all registered fields SHALL take the bubble values of REQ-018, overriding flush and stall.
REQ-029 After reset o_valid=0, o_load_use_hazard=0 and all control outputs 0 until first valid load.

Structure
REQ-030 ALU control codes (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001) and forward-select encoding (REG 2'b00, EXMEM 2'b01, MEMWB 2'b10) SHALL live in a shared pipeline package.
REQ-031 Forward selection SHALL be one sub-module, fwd_sel, instantiated twice (rs and rt).

Verification
REQ-032 Load add r3=r1+r2 (rs=5, rt=7) -> next cycle o_src1=5, o_src2=7, o_alu_ctrl=0000, o_valid=1.
REQ-033 Registered rs=r4; exmem_rd=4 result 0x11, memwb_rd=4 result 0x22, both write -> o_src1=0x11; drop exmem_reg_write -> 0x22.
REQ-034 rs_addr=0, exmem_rd=0, exmem_reg_write=1, result 0xFF -> o_src1 = stored rs_data, not 0xFF.
REQ-035 Registered lw rd=r8; decode presents rt=r8 -> o_load_use_hazard=1; assert i_stall -> outputs unchanged next cycle.
REQ-036 i_stall and i_flush together -> bubble loaded, o_valid=0, o_mem_write=0.
REQ-037 i_rst_n=0 mid-stream with i_stall=1 -> next cycle all outputs zero, o_valid=0.
